uart_tx: RTL

//   Serial UART transmitter paced by the one-cycle baud_tick pulse from baud_generator.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_tx_if.sv | 24 ++
 rtl/uart_tx.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, default frame constants and parity helper.
// Intended for reuse by a future uart_rx.
package uart_pkg;

    localparam int unsigned DEF_DATA_BITS  = 8;
    localparam int unsigned DEF_PARITY_EN  = 0;
    localparam int unsigned DEF_PARITY_ODD = 0;
    localparam int unsigned DEF_STOP_BITS  = 1;

    typedef enum logic [2:0] {
        StIdle,
        StSync,
        StStart,
        StData,
        StParity,
        StStop
    } tx_state_e;

    // Callers zero-extend narrower words; the extra zero bits leave the XOR unchanged.
    function automatic logic calc_parity(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Parallel byte handshake into the UART transmitter (valid/ready, accept on valid & ready).
interface uart_tx_if
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS = DEF_DATA_BITS
);

    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );

endinterface

// File: rtl/uart_tx.sv
// UART transmitter paced by an external one-cycle baud_tick; frame is start, data LSB first,
// optional parity, then one or two stop bits. All outputs are registered.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS  = DEF_DATA_BITS,
    parameter int unsigned PARITY_EN  = DEF_PARITY_EN,
    parameter int unsigned PARITY_ODD = DEF_PARITY_ODD,
    parameter int unsigned STOP_BITS  = DEF_STOP_BITS
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     baud_tick,
    uart_tx_if.slave s_if,
    output logic     tx,
    output logic     busy
);

    localparam int unsigned      CNT_W     = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_BITS - 1);
    localparam logic             STOP_LAST = (STOP_BITS == 2);

    tx_state_e            r_state,    w_state;
    logic [DATA_BITS-1:0] r_shift,    w_shift;
    logic [CNT_W-1:0]     r_bit_cnt,  w_bit_cnt;
    logic                 r_stop_cnt, w_stop_cnt;
    logic                 r_parity,   w_parity;
    logic                 r_tx,       w_tx;
    logic                 r_ready,    w_ready;
    logic                 r_busy,     w_busy;
    logic                 w_accept;

    // r_ready is only high in StIdle, so accept can only happen there.
    assign w_accept = s_if.tx_valid & r_ready;

    always_comb begin
        w_state    = r_state;
        w_shift    = r_shift;
        w_bit_cnt  = r_bit_cnt;
        w_stop_cnt = r_stop_cnt;
        w_parity   = r_parity;
        w_tx       = r_tx;
        w_ready    = r_ready;
        w_busy     = r_busy;

        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_shift  = s_if.tx_data;
                    w_parity = calc_parity(8'(s_if.tx_data), PARITY_ODD != 0);
                    w_ready  = 1'b0;
                    w_busy   = 1'b1;
                    w_state  = StSync;
                end
            end
            // Wait for a tick so the start bit is a full baud period long.
            StSync: begin
                if (baud_tick) begin
                    w_tx    = 1'b0;
                    w_state = StStart;
                end
            end
            StStart: begin
                if (baud_tick) begin
                    w_tx      = r_shift[0];
                    w_shift   = r_shift >> 1;
                    w_bit_cnt = '0;
                    w_state   = StData;
                end
            end
            StData: begin
                if (baud_tick) begin
                    if (r_bit_cnt != LAST_BIT) begin
                        w_tx      = r_shift[0];
                        w_shift   = r_shift >> 1;
                        w_bit_cnt = r_bit_cnt + CNT_W'(1);
                    end else if (PARITY_EN != 0) begin
                        w_tx    = r_parity;
                        w_state = StParity;
                    end else begin
                        w_tx       = 1'b1;
                        w_stop_cnt = 1'b0;
                        w_state    = StStop;
                    end
                end
            end
            StParity: begin
                if (baud_tick) begin
                    w_tx       = 1'b1;
                    w_stop_cnt = 1'b0;
                    w_state    = StStop;
                end
            end
            StStop: begin
                if (baud_tick) begin
                    if (r_stop_cnt == STOP_LAST) begin
                        w_ready = 1'b1;
                        w_busy  = 1'b0;
                        w_state = StIdle;
                    end else begin
                        w_stop_cnt = 1'b1;
                    end
                end
            end
            default: begin
                w_tx    = 1'b1;
                w_ready = 1'b1;
                w_busy  = 1'b0;
                w_state = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_parity   <= 1'b0;
            r_tx       <= 1'b1;
            r_ready    <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_shift    <= w_shift;
            r_bit_cnt  <= w_bit_cnt;
            r_stop_cnt <= w_stop_cnt;
            r_parity   <= w_parity;
            r_tx       <= w_tx;
            r_ready    <= w_ready;
            r_busy     <= w_busy;
        end
    end

    assign tx            = r_tx;
    assign busy          = r_busy;
    assign s_if.tx_ready = r_ready;

endmodule
